eth_tx_frame_arbiter: RTL and testbench

- Frame-granular round-robin arbiter that shares the single 64-bit MAC TX AXI-Stream input (tx_clk domain, ahead of eth_mac_10g_fifo) between PORTS requesters.
- A grant is held until the granted frame's tlast handshake, so frames never interleave.
- While the link is down, granted frames are drained and counted instead of stalling requesters.

---
 rtl/eth_tx_frame_arbiter.sv | 176 +++++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of the 10G MAC TX stream.
// Grants are held for a whole frame; frames granted while the link is down are drained.
module eth_tx_frame_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int SEL_WIDTH  = $clog2(PORTS),
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [PORTS*DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic [PORTS-1:0]                 s_axis_tvalid,
    output logic [PORTS-1:0]                 s_axis_tready,
    input  logic [PORTS-1:0]                 s_axis_tlast,
    input  logic [PORTS-1:0]                 s_axis_tuser,

    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tuser,

    input  logic                             link_up,

    output logic                             grant_valid,
    output logic [SEL_WIDTH-1:0]             grant_port,
    output logic [CNT_WIDTH-1:0]             frame_count,
    output logic [CNT_WIDTH-1:0]             drop_count
);

    // state | meaning
    // IDLE  | no grant; pick next requester from rr_ptr
    // PASS  | granted frame muxed straight through to the MAC
    // DROP  | granted frame accepted and discarded (link was down at grant)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_WIDTH-1:0]   grant_port_q, grant_port_d;
    logic                   grant_valid_q, grant_valid_d;
    logic [CNT_WIDTH-1:0]   frame_count_q, frame_count_d;
    logic [CNT_WIDTH-1:0]   drop_count_q, drop_count_d;

    logic                   req_found;
    logic [SEL_WIDTH-1:0]   req_sel;
    int                     arb_idx;

    logic [DATA_WIDTH-1:0]  g_tdata;
    logic [KEEP_WIDTH-1:0]  g_tkeep;
    logic                   g_tvalid;
    logic                   g_tlast;
    logic                   g_tuser;

    function automatic logic [SEL_WIDTH-1:0] next_ptr(input logic [SEL_WIDTH-1:0] g);
        if (int'(g) == PORTS - 1) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    // Scan downwards so the lowest rotation offset from rr_ptr wins.
    always_comb begin
        req_found = 1'b0;
        req_sel   = '0;
        arb_idx   = 0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            arb_idx = int'(rr_ptr_q) + k;
            if (arb_idx >= PORTS) begin
                arb_idx = arb_idx - PORTS;
            end
            if (s_axis_tvalid[arb_idx]) begin
                req_found = 1'b1;
                req_sel   = SEL_WIDTH'(arb_idx);
            end
        end
    end

    assign g_tdata  = s_axis_tdata[int'(grant_port_q)*DATA_WIDTH +: DATA_WIDTH];
    assign g_tkeep  = s_axis_tkeep[int'(grant_port_q)*KEEP_WIDTH +: KEEP_WIDTH];
    assign g_tvalid = s_axis_tvalid[grant_port_q];
    assign g_tlast  = s_axis_tlast[grant_port_q];
    assign g_tuser  = s_axis_tuser[grant_port_q];

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_port_d  = grant_port_q;
        grant_valid_d = grant_valid_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;

        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    grant_port_d  = req_sel;
                    grant_valid_d = 1'b1;
                    state_d       = link_up ? ST_PASS : ST_DROP;
                end
            end

            ST_PASS: begin
                m_axis_tdata                = g_tdata;
                m_axis_tkeep                = g_tkeep;
                m_axis_tvalid               = g_tvalid;
                m_axis_tlast                = g_tlast;
                m_axis_tuser                = g_tuser;
                s_axis_tready[grant_port_q] = m_axis_tready;
                if (g_tvalid && m_axis_tready && g_tlast) begin
                    if (frame_count_q != '1) begin
                        frame_count_d = frame_count_q + 1'b1;
                    end
                    rr_ptr_d      = next_ptr(grant_port_q);
                    grant_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end

            ST_DROP: begin
                s_axis_tready[grant_port_q] = 1'b1;
                if (g_tvalid && g_tlast) begin
                    if (drop_count_q != '1) begin
                        drop_count_d = drop_count_q + 1'b1;
                    end
                    rr_ptr_d      = next_ptr(grant_port_q);
                    grant_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end

            default: begin
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // A mid-frame reset simply abandons the frame; the MAC FIFO handles the truncation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_port_q  <= '0;
            grant_valid_q <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_port_q  <= grant_port_d;
            grant_valid_q <= grant_valid_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_port  = grant_port_q;
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: rotation, backpressure, link-down drain,
// counter saturation (narrow-counter instance) and mid-frame reset.
module tb_eth_tx_frame_arbiter;

    localparam int PORTS = 4;
    localparam int DW    = 64;
    localparam int KW    = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PORTS*DW-1:0]   s_axis_tdata;
    logic [PORTS*KW-1:0]   s_axis_tkeep;
    logic [PORTS-1:0]      s_axis_tvalid;
    logic [PORTS-1:0]      s_axis_tready;
    logic [PORTS-1:0]      s_axis_tlast;
    logic [PORTS-1:0]      s_axis_tuser;
    logic [DW-1:0]         m_axis_tdata;
    logic [KW-1:0]         m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;
    logic                  link_up;
    logic                  grant_valid;
    logic [1:0]            grant_port;
    logic [15:0]           frame_count;
    logic [15:0]           drop_count;

    logic [PORTS-1:0]      sat_s_tready;
    logic [DW-1:0]         sat_m_tdata;
    logic [KW-1:0]         sat_m_tkeep;
    logic                  sat_m_tvalid;
    logic                  sat_m_tlast;
    logic                  sat_m_tuser;
    logic                  sat_grant_valid;
    logic [1:0]            sat_grant_port;
    logic [1:0]            sat_frame_count;
    logic [1:0]            sat_drop_count;

    eth_tx_frame_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .link_up       (link_up),
        .grant_valid   (grant_valid),
        .grant_port    (grant_port),
        .frame_count   (frame_count),
        .drop_count    (drop_count)
    );

    // 2-bit counters make the saturation boundary reachable in a few frames.
    eth_tx_frame_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW), .CNT_WIDTH(2)) u_dut_sat (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (sat_s_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (sat_m_tdata),
        .m_axis_tkeep  (sat_m_tkeep),
        .m_axis_tvalid (sat_m_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (sat_m_tlast),
        .m_axis_tuser  (sat_m_tuser),
        .link_up       (link_up),
        .grant_valid   (sat_grant_valid),
        .grant_port    (sat_grant_port),
        .frame_count   (sat_frame_count),
        .drop_count    (sat_drop_count)
    );

    always #4 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            src_len  [PORTS];
    int            src_beat [PORTS];
    int            src_tag  [PORTS];
    bit            src_user [PORTS];
    logic [73:0]   out_q[$];
    int            tready_hi[PORTS];
    int            mvalid_cnt;
    int            mirror_err;
    bit            chk_mirror;
    bit            toggle_rdy;
    int            n;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] make_data(input int p, input int tag, input int beat);
        return {16'hC0DE, 8'(p), 8'(tag), 16'(beat), 16'(beat) ^ 16'h5A5A};
    endfunction

    function automatic logic [KW-1:0] make_keep(input int beat, input int len);
        return (beat == len - 1) ? 8'h07 : 8'hFF;
    endfunction

    function automatic bit all_done();
        for (int i = 0; i < PORTS; i++) begin
            if (src_beat[i] < src_len[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < PORTS; i++) begin
            s_axis_tvalid[i]            = (src_beat[i] < src_len[i]);
            s_axis_tdata[i*DW +: DW]    = make_data(i, src_tag[i], src_beat[i]);
            s_axis_tkeep[i*KW +: KW]    = make_keep(src_beat[i], src_len[i]);
            s_axis_tlast[i]             = (src_beat[i] == src_len[i] - 1);
            s_axis_tuser[i]             = src_user[i] && (src_beat[i] == src_len[i] - 1);
        end
    endtask

    task automatic start_frame(input int p, input int tag, input int len, input bit user);
        src_tag[p]  = tag;
        src_len[p]  = len;
        src_beat[p] = 0;
        src_user[p] = user;
        drive();
    endtask

    task automatic clear_stats();
        for (int i = 0; i < PORTS; i++) tready_hi[i] = 0;
        mvalid_cnt = 0;
        mirror_err = 0;
    endtask

    task automatic tick();
        bit hs [PORTS];
        @(negedge clk);
        if (m_axis_tvalid && m_axis_tready)
            out_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
        if (m_axis_tvalid) mvalid_cnt++;
        for (int i = 0; i < PORTS; i++) begin
            hs[i] = s_axis_tvalid[i] && s_axis_tready[i];
            if (s_axis_tready[i]) tready_hi[i]++;
        end
        if (chk_mirror && (s_axis_tready != ((grant_valid && m_axis_tready) ? 4'b0100 : 4'b0000)))
            mirror_err++;
        @(posedge clk);
        #1;
        for (int i = 0; i < PORTS; i++) begin
            if (hs[i]) src_beat[i]++;
        end
        if (toggle_rdy) m_axis_tready = ~m_axis_tready;
        drive();
    endtask

    task automatic run_until_idle(input string tag, input int budget, output int cycles);
        cycles = 0;
        forever begin
            tick();
            cycles++;
            if (all_done() && !grant_valid) break;
            if (cycles >= budget) begin
                chk({tag, "_timeout"}, 128'(cycles), 128'(budget + 1));
                break;
            end
        end
    endtask

    task automatic expect_frame(input string tag, input int p, input int ftag, input int len, input bit user);
        logic [73:0] w;
        logic [73:0] e;
        for (int b = 0; b < len; b++) begin
            e = {make_data(p, ftag, b), make_keep(b, len), (b == len - 1), user && (b == len - 1)};
            if (out_q.size() == 0) begin
                chk({tag, "_missing_beat"}, 128'(0), 128'(e));
            end else begin
                w = out_q.pop_front();
                chk(tag, 128'(w), 128'(e));
            end
        end
    endtask

    task automatic wait_beats(input int p, input int beats);
        int guard = 0;
        while (src_beat[p] < beats && guard < 40) begin
            tick();
            guard++;
        end
        chk("wait_beats_reached", 128'(src_beat[p] >= beats), 128'(1));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < PORTS; i++) begin
            src_len[i] = 0; src_beat[i] = 0; src_tag[i] = 0; src_user[i] = 1'b0;
        end
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        link_up       = 1'b1;
        chk_mirror    = 1'b0;
        toggle_rdy    = 1'b0;
        clear_stats();
        drive();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_grant_valid", 128'(grant_valid), 128'(0));
        chk("rst_grant_port",  128'(grant_port), 128'(0));
        chk("rst_frame_count", 128'(frame_count), 128'(0));
        chk("rst_drop_count",  128'(drop_count), 128'(0));
        chk("rst_s_tready",    128'(s_axis_tready), 128'(0));
        chk("rst_m_tvalid",    128'(m_axis_tvalid), 128'(0));
        chk("rst_m_outputs",   128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 128'(0));
        rst = 1'b0;
        out_q.delete();

        // all four ports at once: rotation 0,1,2,3 with one idle cycle between frames
        for (int p = 0; p < PORTS; p++) start_frame(p, 1, 3, 1'b0);
        run_until_idle("t1", 40, n);
        chk("t1_cycles", 128'(n), 128'(16));
        expect_frame("t1_p0", 0, 1, 3, 1'b0);
        expect_frame("t1_p1", 1, 1, 3, 1'b0);
        expect_frame("t1_p2", 2, 1, 3, 1'b0);
        expect_frame("t1_p3", 3, 1, 3, 1'b0);
        chk("t1_frame_count", 128'(frame_count), 128'(4));

        // port 2, 8 beats under alternating backpressure
        clear_stats();
        chk_mirror = 1'b1;
        toggle_rdy = 1'b1;
        start_frame(2, 2, 8, 1'b1);
        run_until_idle("t2", 40, n);
        chk_mirror    = 1'b0;
        toggle_rdy    = 1'b0;
        m_axis_tready = 1'b1;
        expect_frame("t2_p2", 2, 2, 8, 1'b1);
        chk("t2_tready_mirror", 128'(mirror_err), 128'(0));
        chk("t2_tready2_cycles", 128'(tready_hi[2]), 128'(8));
        chk("t2_other_tready", 128'(tready_hi[0] + tready_hi[1] + tready_hi[3]), 128'(0));
        chk("t2_frame_count", 128'(frame_count), 128'(5));

        // link down: port 1 frame is drained
        clear_stats();
        link_up = 1'b0;
        start_frame(1, 3, 5, 1'b0);
        run_until_idle("t3", 20, n);
        chk("t3_cycles", 128'(n), 128'(6));
        chk("t3_m_tvalid_seen", 128'(mvalid_cnt), 128'(0));
        chk("t3_tready1_cycles", 128'(tready_hi[1]), 128'(5));
        chk("t3_drop_count", 128'(drop_count), 128'(1));
        chk("t3_frame_count", 128'(frame_count), 128'(5));
        chk("t3_no_output", 128'(out_q.size()), 128'(0));

        // link falls mid PASS frame; the next frame (port 3) is dropped
        link_up = 1'b1;
        start_frame(0, 4, 6, 1'b0);
        wait_beats(0, 3);
        link_up = 1'b0;
        run_until_idle("t4a", 20, n);
        expect_frame("t4_p0", 0, 4, 6, 1'b0);
        chk("t4_frame_count", 128'(frame_count), 128'(6));
        clear_stats();
        start_frame(3, 5, 2, 1'b0);
        run_until_idle("t4b", 20, n);
        chk("t4_m_tvalid_seen", 128'(mvalid_cnt), 128'(0));
        chk("t4_drop_count", 128'(drop_count), 128'(2));
        chk("t4_no_output", 128'(out_q.size()), 128'(0));

        // single-beat frames, ports 1 and 2 together after rr wrapped to 0
        link_up = 1'b1;
        start_frame(1, 6, 1, 1'b1);
        start_frame(2, 7, 1, 1'b0);
        run_until_idle("t5", 20, n);
        chk("t5_cycles", 128'(n), 128'(4));
        expect_frame("t5_p1", 1, 6, 1, 1'b1);
        expect_frame("t5_p2", 2, 7, 1, 1'b0);
        chk("t5_frame_count", 128'(frame_count), 128'(8));
        chk("t5_sat_frame_count", 128'(sat_frame_count), 128'(3));
        chk("t5_sat_drop_count", 128'(sat_drop_count), 128'(2));

        // reset in the middle of a PASS frame from port 1
        start_frame(1, 8, 4, 1'b0);
        wait_beats(1, 2);
        rst = 1'b1;
        src_len[1] = 0;
        drive();
        tick();
        chk("t6_grant_valid", 128'(grant_valid), 128'(0));
        chk("t6_s_tready", 128'(s_axis_tready), 128'(0));
        chk("t6_m_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("t6_frame_count", 128'(frame_count), 128'(0));
        chk("t6_drop_count", 128'(drop_count), 128'(0));
        rst = 1'b0;
        out_q.delete();
        // rr_ptr back at 0 means port 0 wins over port 3
        start_frame(3, 9, 2, 1'b0);
        start_frame(0, 10, 2, 1'b0);
        run_until_idle("t6", 20, n);
        chk("t6_cycles", 128'(n), 128'(6));
        expect_frame("t6_p0", 0, 10, 2, 1'b0);
        expect_frame("t6_p3", 3, 9, 2, 1'b0);
        chk("t6_frame_count_after", 128'(frame_count), 128'(2));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
